// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared definitions for the 5-stage pipeline controller:
//               divider-handshake FSM state encoding and the default width
//               of the stall-cycle performance counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Divider handshake states.
  //   RUN      : normal flow, a mul/div in EX may launch the divider
  //   DIV_WAIT : divider busy, EX (and everything behind it) is held
  //   DIV_HOLD : result delivered, waiting for the EX instruction to advance
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_HOLD = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF = 32;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/stall_counter.sv
`default_nettype none
// ============================================================================
// Module      : stall_counter
// Description : Free-running wrapping counter with synchronous clear and
//               count enable. Wraps modulo 2^W.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset (clears count)
//               clr_i   - synchronous clear
//               en_i    - increment enable
//               count_o - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module stall_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      // Natural binary overflow gives the modulo-2^W wrap.
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : stall_counter
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central controller for the IF/ID/EX/MEM/WB pipeline. Merges
//               stall requests from every stage into per-stage hold and
//               bubble controls, sequences the divider start/cancel
//               handshake, and counts cycles in which the PC is held.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               conflict_stall       - ID hazard request
//               inst_wait            - IF instruction fetch outstanding
//               data_wait            - MEM data access outstanding
//               div_req_ex           - EX holds a multicycle mul/div
//               div_done             - divider result valid pulse
//               exc_mem              - MEM-stage exception
//               stall_if..stall_mem  - per-stage hold
//               flush_id..flush_wb   - per-stage bubble insert
//               div_start/div_cancel - divider handshake pulses
//               pc_redirect          - PC loads exception vector
//               stall_cycles         - cycles with stall_if asserted
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conflict_stall,
  input  logic             inst_wait,
  input  logic             data_wait,
  input  logic             div_req_ex,
  input  logic             div_done,
  input  logic             exc_mem,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic             div_start,
  output logic             div_cancel,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e state_q;
  state_e state_d;

  logic w_div_stall;

  // The divider stalls EX from the launch cycle until the result arrives.
  // Once the result is in (DIV_HOLD) EX only waits on downstream stages.
  assign w_div_stall = ((state_q == RUN)      && div_req_ex) ||
                       ((state_q == DIV_WAIT) && !div_done);

  // --------------------------------------------------------------------------
  // Stall / bubble / handshake outputs (combinational, zero latency)
  // --------------------------------------------------------------------------
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    flush_wb    = 1'b0;
    div_start   = 1'b0;
    div_cancel  = 1'b0;
    pc_redirect = 1'b0;

    if (rst) begin
      // Keep bubbles flowing into every stage while in reset.
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (exc_mem) begin
      // Exception squashes the whole pipe and redirects fetch; an
      // in-flight division is aborted.
      flush_id    = 1'b1;
      flush_ex    = 1'b1;
      flush_mem   = 1'b1;
      flush_wb    = 1'b1;
      pc_redirect = 1'b1;
      div_cancel  = (state_q == DIV_WAIT);
    end else begin
      // Each stage holds if it is itself blocked or anything ahead is.
      stall_mem = data_wait;
      stall_ex  = w_div_stall    | stall_mem;
      stall_id  = conflict_stall | stall_ex;
      stall_if  = inst_wait      | stall_id;

      // A bubble enters a stage exactly where a held stage meets a
      // moving one.
      flush_id  = stall_if  & ~stall_id;
      flush_ex  = stall_id  & ~stall_ex;
      flush_mem = stall_ex  & ~stall_mem;
      flush_wb  = stall_mem;

      div_start = (state_q == RUN) && div_req_ex;
    end
  end

  // --------------------------------------------------------------------------
  // Divider handshake FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (exc_mem) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (div_req_ex) state_d = DIV_WAIT;
        end
        DIV_WAIT: begin
          if (div_done) state_d = DIV_HOLD;
        end
        DIV_HOLD: begin
          // Leaving only when EX advances keeps the same mul/div from
          // relaunching while it sits behind a MEM wait.
          if (!stall_ex) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stall-cycle performance counter (exception cycles have stall_if=0)
  // --------------------------------------------------------------------------
  stall_counter #(
    .W (CNT_W)
  ) u_stall_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .en_i    (stall_if),
    .count_o (stall_cycles)
  );

endmodule : pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage IF/ID/EX/MEM/WB core. It consumes stall requests: load-use/branch conflict from ID, multicycle mul/div from EX, SRAM data wait from MEM, and fetch wait from IF. It also consumes the MEM-stage exception. From these it drives per-stage hold and bubble (flush) signals, runs the divider start/cancel handshake, and keeps a stall-cycle performance counter.

Parameters:
CNT_W, 32, width of stall_cycles counter (wraps at 2^CNT_W).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
conflict_stall  in  1  hazard request from ID (load-use / branch operand not ready)
inst_wait  in  1  IF fetch not yet returned by instruction SRAM
data_wait  in  1  MEM data SRAM access not complete
div_req_ex  in  1  EX instruction is a multicycle mul/div
div_done  in  1  divider result valid (one-cycle pulse)
exc_mem  in  1  exception raised by MEM-stage instruction
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
stall_mem  out  1  hold EX/MEM register
flush_id  out  1  load bubble into IF/ID
flush_ex  out  1  load bubble into ID/EX
flush_mem  out  1  load bubble into EX/MEM
flush_wb  out  1  load bubble into MEM/WB
div_start  out  1  one-cycle start pulse to divider
div_cancel  out  1  one-cycle abort pulse to divider
pc_redirect  out  1  PC takes exception vector this cycle
stall_cycles  out  CNT_W  count of cycles with stall_if=1

Behaviour:
- One clock, clk; reset synchronous active-high on rst. In any cycle with rst=1, next state=RUN and stall_cycles<=0. Outputs during rst: all stall_*=0, all flush_*=1, div_start=div_cancel=pc_redirect=0.
- FSM states: RUN, DIV_WAIT, DIV_HOLD.
  - RUN -> DIV_WAIT when div_req_ex=1 and exc_mem=0; div_start=1 that cycle.
  - DIV_WAIT -> DIV_HOLD on div_done=1.
  - DIV_HOLD -> RUN when stall_ex=0, i.e. the EX instruction advances. This prevents re-issuing div_start while EX is held by data_wait.
  - Any state with exc_mem=1 -> RUN. div_cancel=1 if the state was DIV_WAIT.
- div_stall = (state==RUN & div_req_ex) | (state==DIV_WAIT & ~div_done). DIV_HOLD itself never stalls.
- Combinational stall chain (exc_mem=0):
  - stall_mem = data_wait
  - stall_ex = div_stall | stall_mem
  - stall_id = conflict_stall | stall_ex
  - stall_if = inst_wait | stall_id
- Bubbles:
  - flush_id = stall_if & ~stall_id
  - flush_ex = stall_id & ~stall_ex
  - flush_mem = stall_ex & ~stall_mem
  - flush_wb = stall_mem
- Exception priority (exc_mem=1, overrides everything except rst):
  - all stall_*=0
  - flush_id, flush_ex, flush_mem, flush_wb = 1
  - pc_redirect=1
  - div_start=0
- Priority order: rst > exc_mem > data_wait > div > conflict_stall > inst_wait.
- div_start and div_cancel are never high in the same cycle.
- All outputs except stall_cycles are combinational from inputs and state, with zero latency.
- stall_cycles increments by 1 at each clock edge where rst=0 and stall_if=1, wrapping modulo 2^CNT_W. exc_mem cycles do not count.
- div_done arriving in RUN or DIV_HOLD is ignored.

Decomposition:
- Shared package (pipe_pkg): FSM state encoding (RUN=2'd0, DIV_WAIT=2'd1, DIV_HOLD=2'd2) and the CNT_W default.
- One natural sub-module: stall_counter, the CNT_W wrapping counter with sync clear and enable.
- FSM and stall/flush logic stay in pipe_ctrl.

Test Plan:
1. rst=1 for 2 cycles, then all requests 0 -> during rst all flush_*=1, stalls 0; after release all outputs 0, stall_cycles=0.
2. conflict_stall=1 for 1 cycle -> stall_if=stall_id=1, flush_ex=1, stall_ex=0; stall_cycles=1 next cycle.
3. div_req_ex=1, div_done pulses 5 cycles after start -> div_start=1 only in first cycle; stall_ex=1 for 5 cycles; stall_ex=0 in the div_done cycle; FSM reaches DIV_HOLD then RUN; no second div_start.
4. Divider completes (div_done) while data_wait=1 for 3 further cycles, div_req_ex held -> FSM stays DIV_HOLD; stall_mem=1, flush_wb=1 each cycle; div_start stays 0; RUN once data_wait drops.
5. exc_mem=1 in third cycle of DIV_WAIT -> div_cancel=1, pc_redirect=1, all four flush=1, all stalls=0; FSM=RUN next cycle.
6. inst_wait=1 with CNT_W=4 for 17 consecutive cycles -> flush_id=1 each cycle, stall_id=0; stall_cycles wraps 15->0 and ends at 1.
